// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared constants for the N-input round-robin/fixed mux.
//               MODE_FIXED / MODE_RR encode the 'mode' input of mux_nin_rr.
//               WIDTH_DEF / N_IN_DEF are the default data width and channel
//               count.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int WIDTH_DEF = 32;
  localparam int N_IN_DEF  = 3;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_nin_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant. The search starts at channel
//               ptr+1 (mod N_IN) and moves upward. The first requesting
//               channel gets a one-hot grant. When nothing requests, grant is
//               all zeros.
// Ports       : req   [N_IN]  per-channel request
//               ptr   [SEL_W] index of the most recently granted channel
//               grant [N_IN]  one-hot grant (or zero)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_IN-1:0]  grant
);

  // Scan offsets 1..N_IN from ptr. Offset N_IN wraps back to ptr itself, so a
  // lone requester keeps its grant. Both loop indices are constant after
  // unrolling, so no variable bit-select is needed.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N_IN; k++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % N_IN) == i)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_nin_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux_nin_rr
// Description : N-input to 1-output mux with a single registered output
//               stage and valid/ready handshakes on both sides.
//               The channel can be chosen in two ways:
//                 - fixed: the channel given by 'sel'
//                 - round-robin: available only when MUX_RR_EN is defined
//               Without MUX_RR_EN, 'mode' is ignored and the mux always runs
//               in fixed mode.
// Ports       : clk, rst_n    clock, synchronous active-low reset
//               in_data       packed channels, channel i at [i*WIDTH +: WIDTH]
//               in_valid      per-channel valid
//               in_ready      per-channel accept (combinational)
//               mode          0 = fixed, 1 = round-robin
//               sel           channel index used in fixed mode
//               out_data      registered output word
//               out_valid     output register holds an untaken word
//               out_ready     downstream accept
//               out_src       channel index that supplied out_data
//               err_sel       one-cycle pulse after an out-of-range sel
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nin_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_IN  = N_IN_DEF,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_src,
  output logic                  err_sel
);

  logic             load_en;
  logic             fixed_mode;
  logic             sel_ok;
  logic [N_IN-1:0]  grant_fix;
  logic [N_IN-1:0]  grant;
  logic             any_grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_src_q,   out_src_d;
  logic             out_valid_q, out_valid_d;
  logic             err_sel_q,   err_sel_d;

  assign load_en = !out_valid_q || out_ready;
  assign sel_ok  = (int'(sel) < N_IN);

  // Fixed-mode grant is decoded per channel. An out-of-range sel therefore
  // matches no channel and produces no grant.
  always_comb begin
    grant_fix = '0;
    for (int i = 0; i < N_IN; i++) begin
      grant_fix[i] = (sel == SEL_W'(i)) && in_valid[i];
    end
  end

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_IN-1:0]  grant_rr;

  assign fixed_mode = (mode == MODE_FIXED);

  rr_arbiter #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (grant_rr)
  );

  assign grant = fixed_mode ? grant_fix : grant_rr;

  // ptr only moves on a real round-robin load. Fixed-mode traffic leaves it
  // untouched, so the rotation resumes where it left off after a mode change.
  assign ptr_d = (!fixed_mode && load_en && any_grant) ? grant_idx : ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= SEL_W'(N_IN - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign fixed_mode  = 1'b1;
  assign grant       = grant_fix;
`endif

  assign any_grant = |grant;

  // Convert the one-hot grant into a channel index and select its data word.
  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant[i]) begin
        grant_idx  = SEL_W'(i);
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = (rst_n && load_en) ? grant : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load_en) begin
      out_valid_d = any_grant;
      if (any_grant) begin
        out_data_d = grant_data;
        out_src_d  = grant_idx;
      end
    end
    err_sel_d = fixed_mode && !sel_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      err_sel_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      err_sel_q   <= err_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign err_sel   = err_sel_q;

endmodule : mux_nin_rr
`default_nettype wire

// File: tb/tb_mux_nin_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_nin_rr
// Description : Directed, self-checking bench for mux_nin_rr (3 x 32-bit).
//               Channel data is 0 / 700 / 128. Round-robin scenarios run only
//               when MUX_RR_EN is defined. Otherwise the bench checks that
//               'mode' is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nin_rr;

  localparam int WIDTH = 32;
  localparam int N_IN  = 3;
  localparam int SEL_W = 2;

  logic                  clk;
  logic                  rst_n;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SEL_W-1:0]      out_src;
  logic                  err_sel;

  int n_checks = 0;
  int n_fail   = 0;

  mux_nin_rr #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .err_sel   (err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] s);
    chk_eq({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk_eq({tag, "_data"},  64'(out_data),  64'(d));
    chk_eq({tag, "_src"},   64'(out_src),   64'(s));
  endtask

`ifdef MUX_RR_EN
  logic [31:0] exp_rr_d [5] = '{32'd0, 32'd700, 32'd128, 32'd0, 32'd700};
  logic [1:0]  exp_rr_s [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
  logic [31:0] exp_alt  [3] = '{32'd700, 32'd128, 32'd700};
`endif

  initial begin
    rst_n     = 1'b0;
    in_data   = {32'd128, 32'd700, 32'd0};
    in_valid  = 3'b111;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;

    // Reset state. in_ready must stay low even though channel 0 is requesting.
    tick();
    tick();
    chk_out("reset", 1'b0, 32'd0, 2'd0);
    chk_eq("reset_err", 64'(err_sel), 64'd0);
    chk_eq("reset_ready", 64'(in_ready), 64'd0);

    // Fixed mode, with sel stepping through 0, 1, 2.
    rst_n = 1'b1;
    #1 chk_eq("fix0_ready", 64'(in_ready), 64'b001);
    tick();
    chk_out("fix0", 1'b1, 32'd0, 2'd0);
    sel = 2'd1;
    #1 chk_eq("fix1_ready", 64'(in_ready), 64'b010);
    tick();
    chk_out("fix1", 1'b1, 32'd700, 2'd1);
    sel = 2'd2;
    #1 chk_eq("fix2_ready", 64'(in_ready), 64'b100);
    tick();
    chk_out("fix2", 1'b1, 32'd128, 2'd2);

    // Out-of-range sel gives no grant and a single err_sel pulse.
    sel = 2'd3;
    #1 chk_eq("bad_ready", 64'(in_ready), 64'b000);
    chk_eq("bad_err_pre", 64'(err_sel), 64'd0);
    tick();
    chk_eq("bad_valid", 64'(out_valid), 64'd0);
    chk_eq("bad_err", 64'(err_sel), 64'd1);
    sel = 2'd0;
    tick();
    chk_eq("bad_err_end", 64'(err_sel), 64'd0);
    chk_out("recov", 1'b1, 32'd0, 2'd0);

    // Backpressure: the output must hold and no input may be accepted.
    sel       = 2'd1;
    out_ready = 1'b0;
    #1 chk_eq("stall_ready", 64'(in_ready), 64'b000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("stall", 1'b1, 32'd0, 2'd0);
    end
    out_ready = 1'b1;
    #1 chk_eq("release_ready", 64'(in_ready), 64'b010);
    tick();
    chk_out("release", 1'b1, 32'd700, 2'd1);

    // sel points at a channel that is not valid.
    sel      = 2'd2;
    in_valid = 3'b011;
    #1 chk_eq("noval_ready", 64'(in_ready), 64'b000);
    tick();
    chk_eq("noval_valid", 64'(out_valid), 64'd0);
    chk_eq("noval_err", 64'(err_sel), 64'd0);
    in_valid = 3'b111;

`ifndef MUX_RR_EN
    // In the fixed-only build, mode is ignored.
    mode = 1'b1;
    #1 chk_eq("nomode_ready", 64'(in_ready), 64'b100);
    tick();
    chk_out("nomode", 1'b1, 32'd128, 2'd2);
    mode = 1'b0;
`else
    sel = 2'd1;
    tick();
    chk_out("preload", 1'b1, 32'd700, 2'd1);
`endif

    // Reset while a word is held: the word must be dropped.
    rst_n = 1'b0;
    tick();
    chk_out("midrst", 1'b0, 32'd0, 2'd0);
    rst_n = 1'b1;

`ifdef MUX_RR_EN
    // Round-robin rotation starting from reset.
    mode = 1'b1;
    #1 chk_eq("rr_ready0", 64'(in_ready), 64'b001);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("rr_seq", 1'b1, exp_rr_d[k], exp_rr_s[k]);
    end

    // Round-robin with channel 0 idle.
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 3'b110;
    #1 chk_eq("rr110_ready", 64'(in_ready), 64'b010);
    for (int k = 0; k < 3; k++) begin
      chk_eq("rr110_ch0", 64'(in_ready[0]), 64'd0);
      tick();
      chk_eq("rr110_data", 64'(out_data), 64'(exp_alt[k]));
    end

    // Reset after granting channel 1: priority goes back to channel 0.
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 3'b111;
    tick();
    chk_out("rrrst_a", 1'b1, 32'd0, 2'd0);
    tick();
    chk_out("rrrst_b", 1'b1, 32'd700, 2'd1);
    rst_n = 1'b0;
    tick();
    chk_eq("rrrst_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    #1 chk_eq("rrrst_ready", 64'(in_ready), 64'b001);
    tick();
    chk_out("rrrst_first", 1'b1, 32'd0, 2'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_nin_rr
`default_nettype wire

// File: doc/mux_nin_rr.md
MUX_NIN_RR -- requirements
Module: mux_nin_rr

Interface
REQ-001 SHALL have parameter WIDTH, 32, data width of every channel and the output.
REQ-002 SHALL have parameter N_IN, 3, number of input channels (legal range 2..16).
REQ-003 SHALL have parameter SEL_W, $clog2(N_IN), width of sel and out_src.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_data  input  N_IN*WIDTH  packed channels, channel i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  N_IN  per-channel data valid.
REQ-008 SHALL have port in_ready  output  N_IN  per-channel accept, combinational.
REQ-009 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port sel  input  SEL_W  channel index used in fixed mode.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_valid  output  1  out_data holds an untaken word.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port out_src  output  SEL_W  index of the channel that supplied out_data.
REQ-015 SHALL have port err_sel  output  1  registered one-cycle pulse on an out-of-range sel.

Function
REQ-016 SHALL hold one output register; load_en = !out_valid || out_ready; full throughput, one word per cycle.
REQ-017 SHALL set in_ready[i] = load_en && grant[i], with at most one grant bit set per cycle.
REQ-018 Fixed mode SHALL grant channel sel only when sel < N_IN and in_valid[sel] = 1.
REQ-019 Fixed mode with sel >= N_IN SHALL grant nothing and pulse err_sel high for exactly one cycle on the following edge, once per cycle the condition holds.
REQ-020 Round-robin mode SHALL search from channel ptr+1 (mod N_IN) upward and grant the first channel with valid set; ptr SHALL update to the granted index only on an actual load.
REQ-021 SHALL load out_data, out_src and out_valid = 1 on the edge after a grant with load_en = 1; latency is 1 cycle from grant to out_valid.
REQ-022 SHALL clear out_valid when out_ready = 1 and no grant occurs in that cycle.
REQ-023 SHALL keep out_data and out_src stable while out_valid = 1 and out_ready = 0.
REQ-024 A mode change SHALL take effect on the next grant, with ptr preserved across the change.
REQ-025 With no valid channel, SHALL grant nothing and leave ptr unchanged.

Reset
REQ-026 On rst_n = 0 at a clock edge, SHALL set out_valid = 0, out_data = 0, out_src = 0, err_sel = 0 and ptr = N_IN-1, so that channel 0 has first priority.
REQ-027 While rst_n = 0, SHALL drive in_ready = 0; a word held mid-transfer at reset SHALL be discarded.

Configuration
REQ-028 With macro MUX_RR_EN defined, SHALL implement round-robin mode per REQ-020.
REQ-029 Without MUX_RR_EN, SHALL ignore mode, always operate in fixed mode and omit ptr and the arbiter logic.

Structure
REQ-030 Package mux_pkg SHALL hold the mode constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1, plus the defaults WIDTH_DEF = 32 and N_IN_DEF = 3.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req[N_IN] and ptr; output one-hot grant), instantiated only under MUX_RR_EN.

Verification (in_data channels 0/1/2 = 0/700/128, all in_valid = 1 unless stated, out_ready = 1)
REQ-032 Fixed mode, sel stepping 0,1,2 each cycle -> out_data 0,700,128 one cycle later, out_src 0,1,2, out_valid held at 1.
REQ-033 Fixed mode, sel = 3 -> in_ready = 000, out_valid = 0 next cycle, err_sel = 1 for exactly one cycle.
REQ-034 RR mode from reset -> out_data 0,700,128,0,700 on consecutive cycles, out_src 0,1,2,0,1.
REQ-035 RR mode, in_valid = 3'b110 -> out_data alternates 700,128,700 and channel 0 is never granted.
REQ-036 out_ready = 0 for 3 cycles while out_valid = 1 -> out_data and out_src unchanged, in_ready = 000; the data resumes in order after release.
REQ-037 rst_n = 0 for one edge while out_valid = 1 in RR mode after granting channel 1 -> out_valid = 0 on that edge; the first grant after release is channel 0 (out_data 0).
